// File: rtl/oneclock_fifo_pkg.sv
// ----------------------------------------------------------------------------
// oneclock_fifo_pkg
// Shared constants and sizing helpers for the single-clock FIFO.
//   DSIZE_DEFAULT : default data width in bits
//   ASIZE_DEFAULT : default address width (depth = 2**ASIZE)
//   ptr_width()   : pointer width, one extra wrap bit above the address
//   fifo_depth()  : number of storage words for a given address width
// ----------------------------------------------------------------------------
package oneclock_fifo_pkg;

    localparam int DSIZE_DEFAULT = 16;
    localparam int ASIZE_DEFAULT = 4;

    // The extra MSB distinguishes full from empty when the address bits match
    function automatic int ptr_width(input int asize);
        return asize + 1;
    endfunction

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

endpackage

// File: rtl/oneclock_fifo_mem.sv
// ----------------------------------------------------------------------------
// oneclock_fifo_mem
// 2**ASIZE x DSIZE storage array: synchronous write, asynchronous read, no reset.
// Ports:
//   clk      : write clock (rising edge)
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : combinational read data at raddr_i
// ----------------------------------------------------------------------------
module oneclock_fifo_mem
    import oneclock_fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEFAULT,
    parameter int ASIZE = ASIZE_DEFAULT
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic [ASIZE-1:0] raddr_i,
    output logic [DSIZE-1:0] rdata_o
);

    localparam int DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] mem_q [DEPTH];

    // Storage is deliberately left unreset; the FIFO pointers decide validity
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/oneclock_fifo.sv
// ----------------------------------------------------------------------------
// oneclock_fifo
// Single-clock show-ahead FIFO with registered status flags and fill level.
// Optional statistics (sticky overflow/underflow, high-water mark) are built
// only when the macro ONECLOCK_FIFO_STATS_EN is defined.
// Ports:
//   clk           : sole clock, rising edge
//   rst_n_i       : asynchronous active-low reset
//   clr_err_i     : clear sticky stats (ONECLOCK_FIFO_STATS_EN only)
//   ovf_o         : sticky overflow, write while full (stats only)
//   udf_o         : sticky underflow, read while empty (stats only)
//   hiwater_o     : peak fill level (stats only)
//   winc_i        : write strobe
//   wdata_i       : write data
//   wfull_o       : FIFO full
//   walmostfull_o : level >= AFULL_THRESH
//   rinc_i        : read strobe (pop)
//   rdata_o       : head-of-queue data, valid while rempty_o = 0
//   rempty_o      : FIFO empty
//   level_o       : words currently stored
// ----------------------------------------------------------------------------
module oneclock_fifo
    import oneclock_fifo_pkg::*;
#(
    parameter int DSIZE        = DSIZE_DEFAULT,
    parameter int ASIZE        = ASIZE_DEFAULT,
    parameter int AFULL_THRESH = fifo_depth(ASIZE) - 2
) (
    input  logic             clk,
    input  logic             rst_n_i,
`ifdef ONECLOCK_FIFO_STATS_EN
    input  logic             clr_err_i,
    output logic             ovf_o,
    output logic             udf_o,
    output logic [ASIZE:0]   hiwater_o,
`endif
    input  logic             winc_i,
    input  logic [DSIZE-1:0] wdata_i,
    output logic             wfull_o,
    output logic             walmostfull_o,
    input  logic             rinc_i,
    output logic [DSIZE-1:0] rdata_o,
    output logic             rempty_o,
    output logic [ASIZE:0]   level_o
);

    localparam int              PW        = ptr_width(ASIZE);
    localparam int              DEPTH     = fifo_depth(ASIZE);
    localparam logic [PW-1:0]   AFULL_LVL = PW'(AFULL_THRESH);
    localparam logic [PW-1:0]   FULL_XOR  = {1'b1, {ASIZE{1'b0}}};

    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_thresh
        $error("oneclock_fifo: AFULL_THRESH %0d outside 1..%0d", AFULL_THRESH, DEPTH);
    end

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          wr_acc, rd_acc;

    // Acceptance is gated by the registered flags of the current cycle, so a
    // pop cannot make room for a push (or vice versa) in the same edge
    always_comb begin
        wr_acc  = winc_i & ~full_q;
        rd_acc  = rinc_i & ~empty_q;
        wptr_d  = wptr_q + PW'(wr_acc);
        rptr_d  = rptr_q + PW'(rd_acc);
        level_d = wptr_d - rptr_d;
        full_d  = ((wptr_d ^ rptr_d) == FULL_XOR);
        empty_d = (wptr_d == rptr_d);
        afull_d = (level_d >= AFULL_LVL);
    end

    // Pointers and all status flags move together on the same edge
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            afull_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            afull_q <= afull_d;
        end
    end

    oneclock_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[ASIZE-1:0]),
        .wdata_i (wdata_i),
        .raddr_i (rptr_q[ASIZE-1:0]),
        .rdata_o (rdata_o)
    );

    assign wfull_o       = full_q;
    assign rempty_o      = empty_q;
    assign walmostfull_o = afull_q;
    assign level_o       = level_q;

`ifdef ONECLOCK_FIFO_STATS_EN
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic [PW-1:0] hiw_q, hiw_d;

    // A new event or level update on the same edge overrides a clear request
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        hiw_d = hiw_q;
        if (clr_err_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
            hiw_d = level_d;
        end else if (level_d > hiw_q) begin
            hiw_d = level_d;
        end
        if (winc_i && full_q) begin
            ovf_d = 1'b1;
        end
        if (rinc_i && empty_q) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            hiw_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            hiw_q <= hiw_d;
        end
    end

    assign ovf_o     = ovf_q;
    assign udf_o     = udf_q;
    assign hiwater_o = hiw_q;
`endif

endmodule

// File: tb/tb_oneclock_fifo.sv
// ----------------------------------------------------------------------------
// tb_oneclock_fifo
// Randomized self-checking bench for oneclock_fifo against a queue-based
// reference model. Statistics outputs are checked when ONECLOCK_FIFO_STATS_EN
// is defined.
// ----------------------------------------------------------------------------
module tb_oneclock_fifo;

    localparam int DSIZE  = 16;
    localparam int ASIZE  = 4;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 14;

    logic             clk;
    logic             rstN;
    logic             clrErr;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             wafull;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic [ASIZE:0]   level;
`ifdef ONECLOCK_FIFO_STATS_EN
    logic             ovf;
    logic             udf;
    logic [ASIZE:0]   hiwater;
`endif

    int vectorCount = 0;
    int missCount   = 0;

    // Reference model: the queue holds the stored words in order
    logic [DSIZE-1:0] modelQ[$];
    bit               modelOvf;
    bit               modelUdf;
    int               modelHw;

    oneclock_fifo dut (
        .clk           (clk),
        .rst_n_i       (rstN),
`ifdef ONECLOCK_FIFO_STATS_EN
        .clr_err_i     (clrErr),
        .ovf_o         (ovf),
        .udf_o         (udf),
        .hiwater_o     (hiwater),
`endif
        .winc_i        (winc),
        .wdata_i       (wdata),
        .wfull_o       (wfull),
        .walmostfull_o (wafull),
        .rinc_i        (rinc),
        .rdata_o       (rdata),
        .rempty_o      (rempty),
        .level_o       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare all DUT outputs against the model's current contents
    task automatic checkAll();
        checkOutput("level", 32'(level), 32'(modelQ.size()));
        checkOutput("rempty", 32'(rempty), 32'(modelQ.size() == 0));
        checkOutput("wfull", 32'(wfull), 32'(modelQ.size() == DEPTH));
        checkOutput("afull", 32'(wafull), 32'(modelQ.size() >= AFULL));
        if (modelQ.size() > 0) begin
            checkOutput("rdata", 32'(rdata), 32'(modelQ[0]));
        end
`ifdef ONECLOCK_FIFO_STATS_EN
        checkOutput("ovf", 32'(ovf), 32'(modelOvf));
        checkOutput("udf", 32'(udf), 32'(modelUdf));
        checkOutput("hiwater", 32'(hiwater), 32'(modelHw));
`endif
    endtask

    // Advance the model by one clock edge using the pre-edge occupancy
    task automatic modelStep(input bit w, input logic [DSIZE-1:0] d, input bit r, input bit clr);
        int pre;
        logic [DSIZE-1:0] dropped;
        pre = modelQ.size();
        if (clr) begin
            modelOvf = 1'b0;
            modelUdf = 1'b0;
        end
        if (w && pre == DEPTH) modelOvf = 1'b1;
        if (r && pre == 0) modelUdf = 1'b1;
        if (r && pre > 0) dropped = modelQ.pop_front();
        if (w && pre < DEPTH) modelQ.push_back(d);
        if (clr) modelHw = modelQ.size();
        else if (modelQ.size() > modelHw) modelHw = modelQ.size();
    endtask

    // Drive one cycle of stimulus from a negedge, then check at the next negedge
    task automatic applyStimulus(input bit w, input logic [DSIZE-1:0] d, input bit r, input bit clr);
        winc   = w;
        wdata  = d;
        rinc   = r;
        clrErr = clr;
        @(posedge clk);
        modelStep(w, d, r, clr);
        @(negedge clk);
        winc   = 1'b0;
        rinc   = 1'b0;
        clrErr = 1'b0;
        checkAll();
    endtask

    task automatic drainAll();
        for (int i = 0; i < 40 && modelQ.size() > 0; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic fillTo(input int n);
        for (int i = 0; i < 40 && modelQ.size() < n; i++) begin
            applyStimulus(1'b1, DSIZE'($urandom), 1'b0, 1'b0);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelOvf = 1'b0;
        modelUdf = 1'b0;
        modelHw  = 0;
    endtask

    task automatic randomPhase(input int cycles, input int wPct, input int rPct);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus($urandom_range(0, 99) < wPct, DSIZE'($urandom),
                          $urandom_range(0, 99) < rPct, 1'b0);
        end
    endtask

    initial begin
        rstN   = 1'b0;
        winc   = 1'b0;
        rinc   = 1'b0;
        clrErr = 1'b0;
        wdata  = '0;
        modelReset();

        // Reset values
        #12;
        checkAll();
        @(negedge clk);
        rstN = 1'b1;

        // Fill with 1..16; almost-full and full tracked every cycle
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b1, DSIZE'(i), 1'b0, 1'b0);
        end
        checkOutput("full_after16", 32'(wfull), 32'd1);
        checkOutput("level_after16", 32'(level), 32'd16);

        // Write while full is dropped
        applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
        checkOutput("dead_ignored_level", 32'(level), 32'd16);

        // Drain in order
        for (int i = 1; i <= DEPTH; i++) begin
            checkOutput("drain_order", 32'(rdata), 32'(i));
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("empty_after_drain", 32'(rempty), 32'd1);

        // One-cycle write-to-read latency, then pop and underflow attempt
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
        checkOutput("latency_data", 32'(rdata), 32'h1234);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Empty with simultaneous push and pop: only the push lands
        applyStimulus(1'b1, 16'h0F0F, 1'b1, 1'b0);
        checkOutput("empty_rw_level", 32'(level), 32'd1);

        // Level 8 steady state across pointer wrap
        fillTo(8);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, DSIZE'($urandom), 1'b1, 1'b0);
        end
        checkOutput("steady_level", 32'(level), 32'd8);

        // Full with simultaneous push and pop: only the pop lands
        fillTo(DEPTH);
        applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
        checkOutput("full_rw_level", 32'(level), 32'd15);

        // Random traffic biased toward full, then toward empty
        randomPhase(150, 80, 30);
        randomPhase(150, 30, 80);
        randomPhase(100, 50, 50);

        // Asynchronous reset mid-burst at level 5
        drainAll();
        fillTo(5);
        #2;
        rstN = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_empty", 32'(rempty), 32'd1);
        checkOutput("rst_full", 32'(wfull), 32'd0);
        checkOutput("rst_afull", 32'(wafull), 32'd0);
`ifdef ONECLOCK_FIFO_STATS_EN
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_hiwater", 32'(hiwater), 32'd0);
`endif
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b1, 16'h5A5A, 1'b0, 1'b0);
        checkOutput("post_rst_data", 32'(rdata), 32'h5A5A);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Underflow, peak of 11, drain to 3, then clear
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        fillTo(11);
        drainAll();
        fillTo(3);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
`ifdef ONECLOCK_FIFO_STATS_EN
        checkOutput("clr_hiwater", 32'(hiwater), 32'd3);
        checkOutput("clr_ovf", 32'(ovf), 32'd0);
        checkOutput("clr_udf", 32'(udf), 32'd0);
`endif
        checkOutput("clr_level", 32'(level), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
